scope_capture_buf: RTL and testbench

- Triggered circular capture buffer for the oscilloscope application.
- Sits downstream of the Zest ADC sample stream, which arrives already in the local-bus clock domain, and upstream of the local-bus read mux in application_top.
- Records 2^BUF_AW samples around a trigger event, with a programmable pre-trigger depth.
- Serves the frozen record to local-bus reads in chronological order.

---
 rtl/scope_cap_pkg.sv | 21 ++
 rtl/scope_capture_buf_if.sv | 32 +++
 rtl/scope_dpram.sv | 31 +++
 rtl/scope_capture_buf.sv | 174 +++++++++++++++++
 tb/tb_scope_capture_buf.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/scope_cap_pkg.sv
// Shared types and constants for the oscilloscope triggered capture buffer.
package scope_cap_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned TRIG_SEL_W = 2;
    localparam int unsigned RD_LAT     = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } cap_state_e;

    // Code 3 is reserved and behaves like TRIG_FORCE.
    localparam logic [TRIG_SEL_W-1:0] TRIG_FORCE = 2'd0;
    localparam logic [TRIG_SEL_W-1:0] TRIG_EXT   = 2'd1;
    localparam logic [TRIG_SEL_W-1:0] TRIG_LEVEL = 2'd2;

endpackage

// File: rtl/scope_capture_buf_if.sv
// ADC sample stream and local-bus read port of the capture buffer.
interface scope_capture_buf_if #(
    parameter int unsigned DW     = 16,
    parameter int unsigned BUF_AW = 13
);

    logic signed [DW-1:0] adc_data;
    logic                 adc_valid;
    logic [BUF_AW-1:0]    lb_addr;
    logic                 lb_rd;
    logic                 lb_rd_valid;
    logic [DW-1:0]        lb_dout;

    modport master (
        output adc_data,
        output adc_valid,
        output lb_addr,
        output lb_rd,
        input  lb_rd_valid,
        input  lb_dout
    );

    modport slave (
        input  adc_data,
        input  adc_valid,
        input  lb_addr,
        input  lb_rd,
        output lb_rd_valid,
        output lb_dout
    );

endinterface

// File: rtl/scope_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module scope_dpram #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/scope_capture_buf.sv
// Triggered circular capture buffer: records 2^BUF_AW samples around a trigger
// with programmable pre-trigger depth and serves the frozen record oldest-first.
module scope_capture_buf
    import scope_cap_pkg::*;
#(
    parameter int unsigned BUF_AW = 13,
    parameter int unsigned DW     = 16
) (
    input  logic                    lb_clk,
    input  logic                    reset,
    scope_capture_buf_if.slave      bus,
    input  logic                    arm,
    input  logic                    force_trig,
    input  logic                    trig_ext,
    input  logic [TRIG_SEL_W-1:0]   trig_sel,
    input  logic signed [DW-1:0]    trig_level,
    input  logic [BUF_AW-1:0]       pretrig,
    output logic [STATE_W-1:0]      state,
    output logic                    done,
    output logic [BUF_AW-1:0]       trig_addr
);

    cap_state_e           state_q, state_nxt;
    logic [BUF_AW-1:0]    wr_ptr_q, wr_ptr_nxt;
    logic [BUF_AW-1:0]    cnt_q, cnt_nxt;
    logic [BUF_AW-1:0]    pre_q, pre_nxt;
    logic [BUF_AW-1:0]    trig_addr_nxt;
    logic                 pend_q, pend_nxt;
    logic                 done_nxt;
    logic signed [DW-1:0] prev_sample_q;
    logic                 prev_ext_q;

    logic                 wr_en_c;
    logic                 trig_hit_c;
    logic                 ext_edge_c;
    logic                 level_cross_c;
    logic [BUF_AW-1:0]    fill_inc_c;
    logic [BUF_AW-1:0]    post_len_c;
    logic [BUF_AW-1:0]    rd_raw_c;

    logic                 rd_v1_q;
    logic [DW-1:0]        ram_rd_data;

    assign state = state_q;

    // Trigger conditions; only acted on for qualified samples in WAIT_TRIG.
    assign ext_edge_c    = trig_ext && !prev_ext_q;
    assign level_cross_c = (prev_sample_q < trig_level) && (bus.adc_data >= trig_level);
    assign trig_hit_c    = pend_q || force_trig
                        || ((trig_sel == TRIG_EXT)   && ext_edge_c)
                        || ((trig_sel == TRIG_LEVEL) && level_cross_c);

    assign fill_inc_c = cnt_q + BUF_AW'(1);
    // N - pre - 1 post-trigger samples, which is the bitwise complement of pre.
    assign post_len_c = ~pre_q;

    always_comb begin
        state_nxt     = state_q;
        wr_ptr_nxt    = wr_ptr_q;
        cnt_nxt       = cnt_q;
        pre_nxt       = pre_q;
        pend_nxt      = pend_q;
        trig_addr_nxt = trig_addr;
        wr_en_c       = 1'b0;

        if (arm) begin
            pre_nxt   = pretrig;
            pend_nxt  = 1'b0;
            cnt_nxt   = '0;
            state_nxt = (pretrig == '0) ? WAIT_TRIG : FILL;
        end else begin
            case (state_q)
                FILL: begin
                    wr_en_c = bus.adc_valid;
                    if (force_trig) begin
                        pend_nxt = 1'b1;
                    end
                    if (bus.adc_valid) begin
                        cnt_nxt = fill_inc_c;
                        if (fill_inc_c == pre_q) begin
                            state_nxt = WAIT_TRIG;
                        end
                    end
                end
                WAIT_TRIG: begin
                    wr_en_c = bus.adc_valid;
                    if (force_trig) begin
                        pend_nxt = 1'b1;
                    end
                    if (bus.adc_valid && trig_hit_c) begin
                        trig_addr_nxt = wr_ptr_q;
                        pend_nxt      = 1'b0;
                        cnt_nxt       = post_len_c;
                        state_nxt     = (post_len_c == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    wr_en_c = bus.adc_valid;
                    if (bus.adc_valid) begin
                        cnt_nxt = cnt_q - BUF_AW'(1);
                        if (cnt_q == BUF_AW'(1)) begin
                            state_nxt = DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
            if (wr_en_c) begin
                wr_ptr_nxt = wr_ptr_q + BUF_AW'(1);
            end
        end
    end

    assign done_nxt = (state_nxt == DONE);

    always_ff @(posedge lb_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            pre_q         <= '0;
            pend_q        <= 1'b0;
            trig_addr     <= '0;
            done          <= 1'b0;
            prev_sample_q <= '0;
            prev_ext_q    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            wr_ptr_q   <= wr_ptr_nxt;
            cnt_q      <= cnt_nxt;
            pre_q      <= pre_nxt;
            pend_q     <= pend_nxt;
            trig_addr  <= trig_addr_nxt;
            done       <= done_nxt;
            prev_ext_q <= trig_ext;
            if (wr_en_c) begin
                prev_sample_q <= bus.adc_data;
            end
        end
    end

    // Record index 0 maps to the oldest stored sample, pre samples before the trigger.
    assign rd_raw_c = trig_addr - pre_q + bus.lb_addr;

    scope_dpram #(
        .AW (BUF_AW),
        .DW (DW)
    ) u_ram (
        .clk     (lb_clk),
        .wr_en   (wr_en_c),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.adc_data),
        .rd_en   (bus.lb_rd),
        .rd_addr (rd_raw_c),
        .rd_data (ram_rd_data)
    );

    // Two-stage read pipeline; reset drops any read in flight.
    always_ff @(posedge lb_clk) begin
        if (reset) begin
            rd_v1_q         <= 1'b0;
            bus.lb_rd_valid <= 1'b0;
            bus.lb_dout     <= '0;
        end else begin
            rd_v1_q         <= bus.lb_rd;
            bus.lb_rd_valid <= rd_v1_q;
            if (rd_v1_q) begin
                bus.lb_dout <= ram_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_scope_capture_buf.sv
// Self-checking bench for scope_capture_buf: directed scenarios plus random
// captures compared against a sample-sequence reference model.
module tb_scope_capture_buf;
    import scope_cap_pkg::*;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;
    localparam int N = 1 << AW;

    logic                 lb_clk = 1'b0;
    logic                 reset;
    logic                 arm;
    logic                 force_trig;
    logic                 trig_ext;
    logic [1:0]           trig_sel;
    logic signed [DW-1:0] trig_level;
    logic [AW-1:0]        pretrig;
    logic [2:0]           state;
    logic                 done;
    logic [AW-1:0]        trig_addr;

    scope_capture_buf_if #(.DW(DW), .BUF_AW(AW)) bus ();

    scope_capture_buf #(.BUF_AW(AW), .DW(DW)) dut (
        .lb_clk     (lb_clk),
        .reset      (reset),
        .bus        (bus),
        .arm        (arm),
        .force_trig (force_trig),
        .trig_ext   (trig_ext),
        .trig_sel   (trig_sel),
        .trig_level (trig_level),
        .pretrig    (pretrig),
        .state      (state),
        .done       (done),
        .trig_addr  (trig_addr)
    );

    always #5 lb_clk = ~lb_clk;

    int checks   = 0;
    int failures = 0;

    // Model state carried across captures.
    int wp      = 0;
    int last_wr = 0;
    bit ext_last = 1'b0;

    // Per-cycle stimulus for one capture (cycles after the arm cycle).
    bit sv[$];
    int sd[$];
    bit sf[$];
    bit se[$];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge lb_clk);
        #1;
        ext_last = trig_ext;
    endtask

    task automatic clear_stim();
        sv.delete(); sd.delete(); sf.delete(); se.delete();
    endtask

    task automatic push_stim(input bit v, input int d, input bit f, input bit e);
        sv.push_back(v); sd.push_back(d); sf.push_back(f); se.push_back(e);
    endtask

    // Issue reads of every record index plus a few random ones, with gaps.
    task automatic do_reads(input int rec[$]);
        bit sr[$];
        int sa[$];
        for (int i = 0; i < N + 4; i++) begin
            sr.push_back(1'b1);
            sa.push_back((i < N) ? i : int'($urandom_range(0, N - 1)));
            if ($urandom_range(0, 2) == 0) begin
                sr.push_back(1'b0);
                sa.push_back(0);
            end
        end
        sr.push_back(1'b0); sa.push_back(0);
        sr.push_back(1'b0); sa.push_back(0);
        for (int j = 0; j < sr.size(); j++) begin
            bus.lb_rd   = sr[j];
            bus.lb_addr = AW'(sa[j]);
            step();
            check("rd_valid", int'(bus.lb_rd_valid), (j > 0) ? int'(sr[j-1]) : 0);
            if (j > 0 && sr[j-1] && bus.lb_rd_valid) begin
                check($sformatf("rd_data[%0d]", sa[j-1]), int'($signed(bus.lb_dout)), rec[sa[j-1]]);
            end
        end
        bus.lb_rd = 1'b0;
    endtask

    task automatic run_capture(input int pre, input int sel, input int lvl,
                               input bit arm_force, input bit arm_ext);
        int wp_arm = wp;
        int last_before = last_wr;
        bit ep[$];
        bit obs_done[$];
        int vals[$];
        int rec[$];
        int vi = 0;
        int trig = -1;
        int dcyc = -1;
        int obs_dcyc = -1;
        int exp_st;
        bit fs = 1'b0;
        bit hit;
        int prev;

        // Arm cycle carries a qualified sample that must not be stored.
        arm = 1'b1; force_trig = arm_force; trig_ext = arm_ext;
        pretrig = AW'(pre); trig_sel = 2'(sel); trig_level = DW'(lvl);
        bus.adc_valid = 1'b1; bus.adc_data = 16'sd12345;
        step();
        arm = 1'b0; force_trig = 1'b0;
        check("arm_state", int'(state), (pre == 0) ? int'(WAIT_TRIG) : int'(FILL));
        check("arm_done", int'(done), 0);

        for (int c = 0; c < sv.size(); c++) begin
            bus.adc_valid = sv[c];
            bus.adc_data  = DW'(sd[c]);
            force_trig    = sf[c];
            trig_ext      = se[c];
            ep.push_back(ext_last);
            step();
            obs_done.push_back(done);
        end
        bus.adc_valid = 1'b0; force_trig = 1'b0; trig_ext = 1'b0;

        // Reference: walk the qualified samples and apply the trigger rules.
        for (int c = 0; c < sv.size(); c++) begin
            if (sf[c]) fs = 1'b1;
            if (sv[c]) begin
                if (trig < 0 && vi >= pre) begin
                    prev = (vi == 0) ? last_before : vals[vi-1];
                    hit = fs || (sel == 1 && se[c] && !ep[c])
                             || (sel == 2 && prev < lvl && sd[c] >= lvl);
                    if (hit) trig = vi;
                end
                vals.push_back(sd[c]);
                if (trig >= 0 && vi == trig + N - pre - 1) begin
                    dcyc = c;
                    break;
                end
                vi++;
            end
        end

        for (int c = 0; c < obs_done.size(); c++) begin
            if (obs_done[c] && obs_dcyc < 0) obs_dcyc = c;
        end
        check("done_cycle", obs_dcyc, dcyc);

        if (dcyc >= 0)                exp_st = int'(DONE);
        else if (trig >= 0)           exp_st = int'(POST);
        else if (vals.size() >= pre)  exp_st = int'(WAIT_TRIG);
        else                          exp_st = int'(FILL);
        check("state", int'(state), exp_st);
        if (trig >= 0) check("trig_addr", int'(trig_addr), (wp_arm + trig) % N);

        wp = (wp_arm + vals.size()) % N;
        if (vals.size() > 0) last_wr = vals[vals.size()-1];

        if (dcyc >= 0) begin
            for (int i = 0; i < N; i++) rec.push_back(vals[trig - pre + i]);
            do_reads(rec);
        end
    endtask

    initial begin
        int t2[$];
        bit e;

        reset = 1'b1; arm = 1'b0; force_trig = 1'b0; trig_ext = 1'b0;
        trig_sel = '0; trig_level = '0; pretrig = '0;
        bus.adc_valid = 1'b0; bus.adc_data = '0; bus.lb_rd = 1'b0; bus.lb_addr = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_state", int'(state), int'(IDLE));
        check("rst_done", int'(done), 0);
        check("rst_rd_valid", int'(bus.lb_rd_valid), 0);
        check("rst_dout", int'(bus.lb_dout), 0);
        check("rst_trig_addr", int'(trig_addr), 0);

        // Ramp with software trigger at sample 10.
        clear_stim();
        for (int c = 0; c < 30; c++) push_stim(1'b1, c, c == 10, 1'b0);
        run_capture(4, 0, 0, 1'b0, 1'b0);

        // Level crossing: rising through 100 triggers, falling does not.
        t2 = '{0, 30, 60, 90, 120, 150, 140, 130,
               120, 60, 80, 90, 110,
               130, 140, 145, 140, 120, 90, 50, 0, 0};
        clear_stim();
        foreach (t2[i]) push_stim(1'b1, t2[i], 1'b0, 1'b0);
        run_capture(8, 2, 100, 1'b0, 1'b0);

        // External edge with zero pre-trigger: ext high at arm, low, then high.
        clear_stim();
        for (int c = 0; c < 26; c++) push_stim(1'b1, 100 + c, 1'b0, (c < 3) || (c >= 6));
        run_capture(0, 1, 0, 1'b0, 1'b1);

        // Force during FILL is held until the first WAIT_TRIG sample.
        clear_stim();
        for (int c = 0; c < 20; c++) push_stim(1'b1, 200 + c, c == 2, 1'b0);
        run_capture(6, 0, 0, 1'b0, 1'b0);

        // Maximum pre-trigger: done right after the trigger sample.
        clear_stim();
        for (int c = 0; c < 24; c++) push_stim(1'b1, 300 + c, c == 20, 1'b0);
        run_capture(15, 2, 30000, 1'b0, 1'b0);

        // Qualifier toggling.
        clear_stim();
        for (int c = 0; c < 60; c++) push_stim(c % 2 == 0, -50 + c, c == 25, 1'b0);
        run_capture(5, 3, 0, 1'b0, 1'b0);

        // Leave a capture in POST, then re-arm with a simultaneous force.
        clear_stim();
        for (int c = 0; c < 10; c++) push_stim(1'b1, 400 + c, c == 5, 1'b0);
        run_capture(3, 0, 0, 1'b0, 1'b0);
        clear_stim();
        for (int c = 0; c < 30; c++) push_stim(1'b1, 500 + c, c == 8, 1'b0);
        run_capture(4, 0, 0, 1'b1, 1'b0);

        // Reset in POST with a read in flight.
        clear_stim();
        for (int c = 0; c < 8; c++) push_stim(1'b1, 600 + c, c == 3, 1'b0);
        run_capture(2, 0, 0, 1'b0, 1'b0);
        bus.lb_rd = 1'b1; bus.lb_addr = '0;
        step();
        bus.lb_rd = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("rr_state", int'(state), int'(IDLE));
        check("rr_done", int'(done), 0);
        check("rr_trig_addr", int'(trig_addr), 0);
        check("rr_rd_valid0", int'(bus.lb_rd_valid), 0);
        step();
        check("rr_rd_valid1", int'(bus.lb_rd_valid), 0);
        wp = 0; last_wr = 0;

        // Randomized captures.
        for (int k = 0; k < 8; k++) begin
            clear_stim();
            e = 1'b0;
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(0, 5) == 0) e = ~e;
                push_stim($urandom_range(0, 9) < 7, int'($urandom_range(0, 400)) - 200,
                          (c == 40) || ($urandom_range(0, 49) == 0), e);
            end
            run_capture(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 200)) - 100,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
